processor_controller: RTL and testbench
=======================================

// Module: processor_controller
// PURPOSE
//   Sequencing controller sitting directly upstream of the 16x16 register file.
//   Owns PC and IR, fetches 16-bit instructions from instruction ROM, decodes
//   them and drives RF read/write addresses + write enable, data-memory and ALU controls.
//   One instruction per Fetch->Decode->Execute pass; LOAD takes one extra cycle.
// PARAMETERS
//   PC_W    7   instruction address width; PC wraps 2^PC_W-1 -> 0
//   DADDR_W 8   data-memory address width (IR[11:4])
// PORTS
//   Clk        in   1        system clock, all state updates on posedge
//   Reset      in   1        synchronous, active-high
//   InstrData  in   16       ROM word at PcAddr, combinational read, valid same cycle
//   PcAddr     out  PC_W     current PC
//   IrOut      out  16       instruction register contents
//   DAddr      out  DADDR_W  data-memory address
//   DWr        out  1        data-memory write enable
//   RfSel      out  1        RF write-data mux: 1=memory read data, 0=ALU result
//   RfWrAddr   out  4        to RF WrAddr
//   RfWren     out  1        to RF Wren
//   RfRdAddrA  out  4        to RF RdAddrA
//   RfRdAddrB  out  4        to RF RdAddrB
//   AluSel     out  3        000=pass A, 001=ADD, 010=SUB
//   StateOut   out  4        current state encoding, debug/visibility
// BEHAVIOUR
//   Reset (sync, sampled on posedge): next state INIT, PC=0, IR=0; all control
//     outputs 0 (DWr, RfWren, RfSel, AluSel, all addresses). Reset mid-instruction aborts it; no write issued that cycle.
//   Opcode IR[15:12]: 0000 NOOP, 0001 STORE, 0010 LOAD, 0011 ADD, 0100 SUB,
//     0101 HALT; 0110-1111 illegal -> executed as NOOP.
//   States/transitions:
//     INIT  -> FETCH (1 cycle after Reset deasserts)
//     FETCH : IR<=InstrData, PC<=PC+1 (mod 2^PC_W) at end of cycle -> DECODE
//     DECODE: no writes; -> NOOP|STORE|LOAD_A|ADD|SUB|HALT per opcode
//     NOOP  -> FETCH
//     STORE : DAddr=IR[11:4], RfRdAddrA=IR[3:0], DWr=1 -> FETCH
//     LOAD_A: DAddr=IR[11:4], RfSel=1, RfWrAddr=IR[3:0], RfWren=0 -> LOAD_B
//     LOAD_B: same as LOAD_A but RfWren=1 (memory has 1-cycle read latency) -> FETCH
//     ADD   : RfRdAddrA=IR[11:8], RfRdAddrB=IR[7:4], RfWrAddr=IR[3:0],
//             AluSel=001, RfSel=0, RfWren=1 -> FETCH
//     SUB   : as ADD with AluSel=010 (A-B, 16-bit wrap, no flags) -> FETCH
//     HALT  : all enables 0, PC/IR frozen; stays until Reset
//   Outputs are Moore: function of state and IR only, never of InstrData.
//   At most one of DWr/RfWren high in any cycle; both 0 in INIT/FETCH/DECODE/NOOP/HALT.
//   Latency: NOOP/STORE/ADD/SUB 3 cycles, LOAD 4 cycles, from FETCH to next FETCH.
//   Address fields not used by the current state drive 0.
//   PC wrap: fetch at PC=127 sets PC=0; no stall.
// TESTING
//   1 Reset held 2 cycles mid-ADD -> next cycle INIT, PC=0, IR=0, RfWren=0, DWr=0.
//   2 ROM[0]=16'h3123 (ADD R3=R1+R2) -> 2nd posedge after FETCH: RfWren=1, RfRdAddrA=1,
//     RfRdAddrB=2, RfWrAddr=3, AluSel=001 for exactly 1 cycle; PC=1.
//   3 ROM[1]=16'h205A (LOAD R10<-M[0x05]) -> LOAD_A RfWren=0, LOAD_B RfWren=1,
//     DAddr=8'h05, RfWrAddr=10, RfSel=1; 4 cycles total.
//   4 ROM[2]=16'h1A57 (STORE M[0xA5]<-R7) -> DWr=1 1 cycle, DAddr=8'hA5,
//     RfRdAddrA=7, RfWren=0.
//   5 ROM[3]=16'h9FFF illegal, then ROM[4]=16'h5000 HALT -> no writes; after HALT
//     PC=5 frozen for 20 cycles, DWr=RfWren=0.
//   6 Preload PC=127 via NOOP stream (ROM all 0) -> fetch at 127 gives PC=0, run continues.

Source files
------------

// File: rtl/processor_controller_if.sv
// Controller-side bus: instruction ROM fetch plus register-file, data-memory and ALU controls.
interface processor_controller_if #(
    parameter int unsigned PC_W    = 7,
    parameter int unsigned DADDR_W = 8
);
    logic [15:0]        InstrData;
    logic [PC_W-1:0]    PcAddr;
    logic [15:0]        IrOut;
    logic [DADDR_W-1:0] DAddr;
    logic               DWr;
    logic               RfSel;
    logic [3:0]         RfWrAddr;
    logic               RfWren;
    logic [3:0]         RfRdAddrA;
    logic [3:0]         RfRdAddrB;
    logic [2:0]         AluSel;
    logic [3:0]         StateOut;

    // Controller side
    modport master (
        input  InstrData,
        output PcAddr, IrOut, DAddr, DWr, RfSel, RfWrAddr, RfWren,
        output RfRdAddrA, RfRdAddrB, AluSel, StateOut
    );

    // ROM / datapath side
    modport slave (
        output InstrData,
        input  PcAddr, IrOut, DAddr, DWr, RfSel, RfWrAddr, RfWren,
        input  RfRdAddrA, RfRdAddrB, AluSel, StateOut
    );
endinterface

// File: rtl/processor_controller.sv
// Fetch/decode/execute sequencer. Owns PC and IR; all control outputs are registered
// and loaded together with the state they belong to, so they depend only on state and IR.
module processor_controller #(
    parameter int unsigned PC_W    = 7,
    parameter int unsigned DADDR_W = 8
) (
    input logic                    Clk,
    input logic                    Reset,
    processor_controller_if.master bus
);
    typedef enum logic [3:0] {
        StInit   = 4'd0,
        StFetch  = 4'd1,
        StDecode = 4'd2,
        StNoop   = 4'd3,
        StStore  = 4'd4,
        StLoadA  = 4'd5,
        StLoadB  = 4'd6,
        StAdd    = 4'd7,
        StSub    = 4'd8,
        StHalt   = 4'd9
    } state_t;

    localparam logic [2:0] AluPass = 3'b000;
    localparam logic [2:0] AluAdd  = 3'b001;
    localparam logic [2:0] AluSub  = 3'b010;

    state_t             r_state;
    logic [PC_W-1:0]    r_pc;
    logic [15:0]        r_ir;
    logic [DADDR_W-1:0] r_daddr;
    logic               r_dwr;
    logic               r_rf_sel;
    logic [3:0]         r_rf_wr_addr;
    logic               r_rf_wren;
    logic [3:0]         r_rf_rd_a;
    logic [3:0]         r_rf_rd_b;
    logic [2:0]         r_alu_sel;

    // State, PC/IR and registered outputs; outputs default to 0 and are set for the state being entered
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state      <= StInit;
            r_pc         <= '0;
            r_ir         <= '0;
            r_daddr      <= '0;
            r_dwr        <= 1'b0;
            r_rf_sel     <= 1'b0;
            r_rf_wr_addr <= '0;
            r_rf_wren    <= 1'b0;
            r_rf_rd_a    <= '0;
            r_rf_rd_b    <= '0;
            r_alu_sel    <= AluPass;
        end else begin
            r_daddr      <= '0;
            r_dwr        <= 1'b0;
            r_rf_sel     <= 1'b0;
            r_rf_wr_addr <= '0;
            r_rf_wren    <= 1'b0;
            r_rf_rd_a    <= '0;
            r_rf_rd_b    <= '0;
            r_alu_sel    <= AluPass;

            case (r_state)
                StInit: r_state <= StFetch;
                StFetch: begin
                    r_ir    <= bus.InstrData;
                    r_pc    <= r_pc + 1'b1;
                    r_state <= StDecode;
                end
                StDecode: begin
                    case (r_ir[15:12])
                        4'h1: begin
                            r_state   <= StStore;
                            r_daddr   <= r_ir[11:4];
                            r_rf_rd_a <= r_ir[3:0];
                            r_dwr     <= 1'b1;
                        end
                        4'h2: begin
                            r_state      <= StLoadA;
                            r_daddr      <= r_ir[11:4];
                            r_rf_sel     <= 1'b1;
                            r_rf_wr_addr <= r_ir[3:0];
                        end
                        4'h3, 4'h4: begin
                            r_state      <= (r_ir[15:12] == 4'h3) ? StAdd : StSub;
                            r_rf_rd_a    <= r_ir[11:8];
                            r_rf_rd_b    <= r_ir[7:4];
                            r_rf_wr_addr <= r_ir[3:0];
                            r_alu_sel    <= (r_ir[15:12] == 4'h3) ? AluAdd : AluSub;
                            r_rf_wren    <= 1'b1;
                        end
                        4'h5:    r_state <= StHalt;
                        default: r_state <= StNoop;  // NOOP and all illegal opcodes
                    endcase
                end
                StLoadA: begin
                    // Second LOAD cycle covers the one-cycle memory read latency
                    r_state      <= StLoadB;
                    r_daddr      <= r_ir[11:4];
                    r_rf_sel     <= 1'b1;
                    r_rf_wr_addr <= r_ir[3:0];
                    r_rf_wren    <= 1'b1;
                end
                StHalt:  r_state <= StHalt;
                default: r_state <= StFetch;
            endcase
        end
    end

    assign bus.PcAddr    = r_pc;
    assign bus.IrOut     = r_ir;
    assign bus.DAddr     = r_daddr;
    assign bus.DWr       = r_dwr;
    assign bus.RfSel     = r_rf_sel;
    assign bus.RfWrAddr  = r_rf_wr_addr;
    assign bus.RfWren    = r_rf_wren;
    assign bus.RfRdAddrA = r_rf_rd_a;
    assign bus.RfRdAddrB = r_rf_rd_b;
    assign bus.AluSel    = r_alu_sel;
    assign bus.StateOut  = r_state;
endmodule

// File: tb/tb_processor_controller.sv
// Directed bench for processor_controller: ROM model drives InstrData from PcAddr.
module tb_processor_controller;
    logic        Clk;
    logic        Reset;
    logic [15:0] rom [128];
    int          n_checks;
    int          n_errors;

    processor_controller_if #(.PC_W(7), .DADDR_W(8)) bus ();

    processor_controller #(.PC_W(7), .DADDR_W(8)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    assign bus.InstrData = rom[bus.PcAddr];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, " DWr"}, {15'd0, bus.DWr}, 16'd0);
        check_val({tag, " RfWren"}, {15'd0, bus.RfWren}, 16'd0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        rom[0] = 16'h3123;
        rom[1] = 16'h205A;
        rom[2] = 16'h1A57;
        rom[3] = 16'h9FFF;
        rom[4] = 16'h5000;

        Reset = 1'b1;
        tick();
        tick();
        check_val("rst state", {12'd0, bus.StateOut}, 16'd0);
        check_val("rst pc", {9'd0, bus.PcAddr}, 16'd0);
        check_val("rst ir", bus.IrOut, 16'h0000);
        check_quiet("rst");

        // Get into ADD, then reset mid-instruction
        Reset = 1'b0;
        tick();
        check_val("fetch state", {12'd0, bus.StateOut}, 16'd1);
        tick();
        tick();
        check_val("add pre-rst state", {12'd0, bus.StateOut}, 16'd7);
        Reset = 1'b1;
        tick();
        tick();
        check_val("midrst state", {12'd0, bus.StateOut}, 16'd0);
        check_val("midrst pc", {9'd0, bus.PcAddr}, 16'd0);
        check_val("midrst ir", bus.IrOut, 16'h0000);
        check_quiet("midrst");
        Reset = 1'b0;

        // ADD R3 = R1 + R2
        tick();
        check_val("fetch0 state", {12'd0, bus.StateOut}, 16'd1);
        tick();
        check_val("dec0 ir", bus.IrOut, 16'h3123);
        check_val("dec0 pc", {9'd0, bus.PcAddr}, 16'd1);
        check_quiet("dec0");
        tick();
        check_val("add state", {12'd0, bus.StateOut}, 16'd7);
        check_val("add RfWren", {15'd0, bus.RfWren}, 16'd1);
        check_val("add RdA", {12'd0, bus.RfRdAddrA}, 16'd1);
        check_val("add RdB", {12'd0, bus.RfRdAddrB}, 16'd2);
        check_val("add WrAddr", {12'd0, bus.RfWrAddr}, 16'd3);
        check_val("add AluSel", {13'd0, bus.AluSel}, 16'd1);
        check_val("add RfSel", {15'd0, bus.RfSel}, 16'd0);
        check_val("add DWr", {15'd0, bus.DWr}, 16'd0);
        tick();
        check_val("add end state", {12'd0, bus.StateOut}, 16'd1);
        check_quiet("add end");
        check_val("add end pc", {9'd0, bus.PcAddr}, 16'd1);

        // LOAD R10 <- M[0x05]
        tick();
        check_val("dec1 ir", bus.IrOut, 16'h205A);
        tick();
        check_val("loada state", {12'd0, bus.StateOut}, 16'd5);
        check_val("loada RfWren", {15'd0, bus.RfWren}, 16'd0);
        check_val("loada DAddr", {8'd0, bus.DAddr}, 16'h0005);
        check_val("loada RfSel", {15'd0, bus.RfSel}, 16'd1);
        check_val("loada WrAddr", {12'd0, bus.RfWrAddr}, 16'd10);
        tick();
        check_val("loadb state", {12'd0, bus.StateOut}, 16'd6);
        check_val("loadb RfWren", {15'd0, bus.RfWren}, 16'd1);
        check_val("loadb DAddr", {8'd0, bus.DAddr}, 16'h0005);
        check_val("loadb RfSel", {15'd0, bus.RfSel}, 16'd1);
        check_val("loadb WrAddr", {12'd0, bus.RfWrAddr}, 16'd10);
        check_val("loadb DWr", {15'd0, bus.DWr}, 16'd0);
        tick();
        check_val("load end state", {12'd0, bus.StateOut}, 16'd1);
        check_quiet("load end");

        // STORE M[0xA5] <- R7
        tick();
        check_val("dec2 ir", bus.IrOut, 16'h1A57);
        tick();
        check_val("store state", {12'd0, bus.StateOut}, 16'd4);
        check_val("store DWr", {15'd0, bus.DWr}, 16'd1);
        check_val("store DAddr", {8'd0, bus.DAddr}, 16'h00A5);
        check_val("store RdA", {12'd0, bus.RfRdAddrA}, 16'd7);
        check_val("store RfWren", {15'd0, bus.RfWren}, 16'd0);
        check_val("store WrAddr", {12'd0, bus.RfWrAddr}, 16'd0);
        tick();
        check_val("store end state", {12'd0, bus.StateOut}, 16'd1);
        check_quiet("store end");

        // Illegal opcode behaves as NOOP
        tick();
        check_val("dec3 ir", bus.IrOut, 16'h9FFF);
        tick();
        check_val("illegal state", {12'd0, bus.StateOut}, 16'd3);
        check_quiet("illegal");
        tick();
        check_val("illegal end state", {12'd0, bus.StateOut}, 16'd1);

        // HALT freezes PC/IR
        tick();
        check_val("dec4 ir", bus.IrOut, 16'h5000);
        tick();
        check_val("halt state", {12'd0, bus.StateOut}, 16'd9);
        for (int i = 0; i < 20; i++) begin
            tick();
            check_val("halt pc", {9'd0, bus.PcAddr}, 16'd5);
            check_val("halt ir", bus.IrOut, 16'h5000);
            check_val("halt state hold", {12'd0, bus.StateOut}, 16'd9);
            check_quiet("halt");
        end

        // PC wrap through a NOOP stream
        for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        begin
            bit found;
            found = 1'b0;
            for (int i = 0; i < 1000 && !found; i++) begin
                tick();
                if (bus.StateOut == 4'd1 && bus.PcAddr == 7'd127) found = 1'b1;
                else check_quiet("noop stream");
            end
            check_val("reach pc127", {15'd0, found}, 16'd1);
        end
        tick();
        check_val("wrap pc", {9'd0, bus.PcAddr}, 16'd0);
        check_val("wrap state", {12'd0, bus.StateOut}, 16'd2);
        tick();
        tick();
        check_val("wrap refetch state", {12'd0, bus.StateOut}, 16'd1);
        tick();
        check_val("wrap next pc", {9'd0, bus.PcAddr}, 16'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
